// File: rtl/button_debounce.sv
// Debounces one raw push-button: 2-flop synchronizer feeding a 4-state stability FSM.
// Latency: 3 + STABLE_CNT clk edges from input change to db_level/pulse update.
// Backpressure: none; outputs are free-running registered levels and pulses.
module button_debounce #(
    parameter int STABLE_CNT = 1_000_000,
    parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic db_press,
    output logic db_release
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        WAIT_H = 2'd1,
        HIGH   = 2'd2,
        WAIT_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    logic             meta;
    logic             sync_q;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta       <= 1'b0;
            sync_q     <= 1'b0;
            state      <= LOW;
            cnt        <= '0;
            db_level   <= 1'b0;
            db_press   <= 1'b0;
            db_release <= 1'b0;
        end else begin
            meta       <= btn_in;
            sync_q     <= meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            db_level   <= level_nxt;
            db_press   <= press_nxt;
            db_release <= release_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            LOW: begin
                if (sync_q) begin
                    state_nxt = WAIT_H;
                    cnt_nxt   = '0;
                end
            end
            WAIT_H: begin
                // a single low sample aborts the attempt; the next one restarts at 0
                if (!sync_q) begin
                    state_nxt = LOW;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HIGH;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync_q) begin
                    state_nxt = WAIT_L;
                    cnt_nxt   = '0;
                end
            end
            WAIT_L: begin
                if (sync_q) begin
                    state_nxt = HIGH;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = LOW;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = LOW;
            end
        endcase
        level_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_L);
    end

endmodule
